// File: rtl/mul_acc_pkg.sv
// Shared types and constants for the multiply-accumulate block.
// State encoding is fixed so that traces and the bench can decode it directly.
package mul_acc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam int WIDTH_DEF = 16;
    localparam int CNT_W_DEF = 4;

    localparam logic [WIDTH_DEF-1:0] ACC_SAT = {WIDTH_DEF{1'b1}};

endpackage

// File: rtl/mul_acc_add.sv
// acc_add: WIDTH-bit unsigned adder with carry-out; saturates to all-ones under MUL_ACC_SAT_EN.
// Latency: combinational. Backpressure: none (pure datapath).
// Once the sum saturates it stays there: all-ones plus a nonzero term carries again, plus zero is unchanged.
module acc_add
    import mul_acc_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    logic [WIDTH:0] raw;

    assign raw   = {1'b0, a} + {1'b0, b};
    assign carry = raw[WIDTH];

`ifdef MUL_ACC_SAT_EN
    assign sum = carry ? {WIDTH{1'b1}} : raw[WIDTH-1:0];
`else
    assign sum = raw[WIDTH-1:0];
`endif

endmodule

// File: rtl/mul_acc.sv
// mul_acc: accumulates a programmed number of multiplier products with a sticky overflow (MUL_ACC_SAT_EN selects saturation).
// Latency: result valid the cycle after the last product is accepted; len=0 gives a zero result the cycle after start.
// Backpressure: in_ready/out_valid come from registered state only; result is held until out_ready.
module mul_acc
    import mul_acc_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] prod,
    input  logic             prod_ovf,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] acc,
    output logic             acc_ovf,
    output logic             busy
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [WIDTH-1:0] add_sum;
    logic             add_carry;

    acc_add #(.WIDTH(WIDTH)) u_add (
        .a     (acc_q),
        .b     (prod),
        .sum   (add_sum),
        .carry (add_carry)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    cnt_d   = len;
                    state_d = (len != '0) ? ST_ACCUM : ST_DONE;
                end
            end
            ST_ACCUM: begin
                if (in_valid) begin
                    acc_d = add_sum;
                    ovf_d = ovf_q | prod_ovf | add_carry;
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready  = (state_q == ST_ACCUM);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign acc       = acc_q;
    assign acc_ovf   = ovf_q;

endmodule

// File: tb/tb_mul_acc.sv
// Directed bench for mul_acc: hand-computed vectors, outputs sampled 1ns after each rising edge.
module tb_mul_acc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [3:0]  len;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] prod;
    logic        prod_ovf;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] acc;
    logic        acc_ovf;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mul_acc dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .prod      (prod),
        .prod_ovf  (prod_ovf),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .acc       (acc),
        .acc_ovf   (acc_ovf),
        .busy      (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [15:0] exp_sat;
`ifdef MUL_ACC_SAT_EN
        exp_sat = 16'hFFFF;
`else
        exp_sat = 16'h0010;
`endif
        rst_n     = 1'b0;
        start     = 1'b0;
        len       = 4'd0;
        in_valid  = 1'b0;
        prod      = 16'h0000;
        prod_ovf  = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_acc", acc, 0);
        check("rst_acc_ovf", acc_ovf, 0);
        rst_n = 1'b1;
        tick();
        check("idle_busy", busy, 0);

        // len=3, back-to-back products
        start = 1'b1; len = 4'd3;
        tick();
        start = 1'b0;
        check("a_in_ready", in_ready, 1);
        check("a_out_valid", out_valid, 0);
        check("a_busy", busy, 1);
        in_valid = 1'b1; prod = 16'h0010;
        tick();
        prod = 16'h0020;
        tick();
        check("a_mid_acc", acc, 16'h0030);
        prod = 16'h0030;
        tick();
        in_valid = 1'b0; prod = 16'h0000;
        check("a_out_valid_done", out_valid, 1);
        check("a_in_ready_done", in_ready, 0);
        check("a_acc", acc, 16'h0060);
        check("a_ovf", acc_ovf, 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("a_idle_out_valid", out_valid, 0);
        check("a_idle_busy", busy, 0);

        // carry-out: wrap or saturate
        start = 1'b1; len = 4'd2;
        tick();
        start = 1'b0;
        in_valid = 1'b1; prod = 16'hFFF0;
        tick();
        prod = 16'h0020;
        tick();
        in_valid = 1'b0; prod = 16'h0000;
        check("b_out_valid", out_valid, 1);
        check("b_acc", acc, exp_sat);
        check("b_ovf", acc_ovf, 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // multiplier overflow flag is sticky
        start = 1'b1; len = 4'd2;
        tick();
        start = 1'b0;
        check("c_acc_cleared", acc, 0);
        check("c_ovf_cleared", acc_ovf, 0);
        in_valid = 1'b1; prod = 16'h0005; prod_ovf = 1'b1;
        tick();
        prod = 16'h0001; prod_ovf = 1'b0;
        tick();
        in_valid = 1'b0; prod = 16'h0000;
        check("c_acc", acc, 16'h0006);
        check("c_ovf", acc_ovf, 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // len=0, result held under backpressure, start ignored while busy
        start = 1'b1; len = 4'd0;
        tick();
        check("d_out_valid", out_valid, 1);
        check("d_acc", acc, 0);
        check("d_ovf", acc_ovf, 0);
        check("d_in_ready", in_ready, 0);
        len = 4'd5;
        for (int i = 0; i < 5; i++) begin
            start = (i % 2 == 0);
            in_valid = 1'b1; prod = 16'h1234;
            tick();
            check("d_hold_out_valid", out_valid, 1);
            check("d_hold_acc", acc, 0);
            check("d_hold_in_ready", in_ready, 0);
        end
        start = 1'b0; in_valid = 1'b0; prod = 16'h0000;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("d_idle_busy", busy, 0);
        check("d_idle_out_valid", out_valid, 0);

        // len=3, gapped in_valid (1,0,0,1,0,1), late out_ready
        start = 1'b1; len = 4'd3;
        tick();
        start = 1'b0;
        in_valid = 1'b1; prod = 16'h0100;
        tick();
        in_valid = 1'b0; prod = 16'hAAAA;
        tick();
        tick();
        check("e_gap_acc", acc, 16'h0100);
        in_valid = 1'b1; prod = 16'h0023;
        tick();
        in_valid = 1'b0; prod = 16'h5555;
        tick();
        check("e_gap_out_valid", out_valid, 0);
        in_valid = 1'b1; prod = 16'h1000;
        tick();
        in_valid = 1'b0; prod = 16'h0000;
        check("e_out_valid", out_valid, 1);
        check("e_acc", acc, 16'h1123);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("e_late_out_valid", out_valid, 1);
            check("e_late_acc", acc, 16'h1123);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("e_idle_out_valid", out_valid, 0);
        check("e_idle_busy", busy, 0);
        tick();
        check("e_single_hs", out_valid, 0);

        // reset mid-ACCUM after 2 of 4 terms
        start = 1'b1; len = 4'd4;
        tick();
        start = 1'b0;
        in_valid = 1'b1; prod = 16'h0011; prod_ovf = 1'b1;
        tick();
        prod = 16'h0022; prod_ovf = 1'b0;
        tick();
        in_valid = 1'b0; prod = 16'h0000;
        check("f_pre_acc", acc, 16'h0033);
        check("f_pre_ovf", acc_ovf, 1);
        rst_n = 1'b0;
        tick();
        check("f_rst_acc", acc, 0);
        check("f_rst_ovf", acc_ovf, 0);
        check("f_rst_in_ready", in_ready, 0);
        check("f_rst_busy", busy, 0);
        rst_n = 1'b1;
        tick();
        start = 1'b1; len = 4'd1;
        tick();
        start = 1'b0;
        in_valid = 1'b1; prod = 16'h0007;
        tick();
        in_valid = 1'b0; prod = 16'h0000;
        check("f_recover_out_valid", out_valid, 1);
        check("f_recover_acc", acc, 16'h0007);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("f_recover_idle", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
